// File: rtl/pipe_add_pkg.sv
// Shared defaults and helpers for the segmented pipelined adder.
package pipe_add_pkg;

  localparam int unsigned PIPE_ADD_WIDTH_DEF = 16;
  localparam int unsigned PIPE_ADD_SEG_DEF   = 4;

  function automatic int unsigned stages(input int unsigned width, input int unsigned seg);
    return (seg == 0) ? 0 : width / seg;
  endfunction

endpackage

// File: rtl/pipe_add_if.sv
// Operand/result handshake bundle for pipe_add; the sat signal exists only
// when PIPE_ADD_SAT_EN is defined.
interface pipe_add_if
  import pipe_add_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_ADD_WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPE_ADD_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef PIPE_ADD_SAT_EN
  modport master (output in_valid, a, b, cin, sat, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, sat, out_ready,
                  output in_ready, out_valid, sum, cout);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/pipe_add_seg.sv
// Combinational SEG-bit ripple-carry segment built from per-bit adder cells.
module pipe_add_seg #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);
  logic [SEG:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    logic p, g;
    // Full adder as two half adders: (p,g) from the operands, then p with the carry.
    assign p      = a[i] ^ b[i];
    assign g      = a[i] & b[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = g | (p & c[i]);
  end

  assign co = c[SEG];

endmodule

// File: rtl/pipe_add.sv
// Pipelined ripple adder: one SEG-bit segment per stage, carry registered between
// stages, global-enable stall. Optional saturation via PIPE_ADD_SAT_EN.
module pipe_add
  import pipe_add_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_ADD_WIDTH_DEF,
  parameter int unsigned SEG   = PIPE_ADD_SEG_DEF
) (
  input  logic      clk,
  input  logic      rst,
  pipe_add_if.slave bus
);
  localparam int unsigned STAGES = stages(WIDTH, SEG);

  if (SEG == 0 || SEG > WIDTH || (WIDTH % SEG) != 0) begin : g_bad_cfg
    $fatal(1, "pipe_add: WIDTH must be a non-zero multiple of SEG");
  end

  logic advance;

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * SEG;
    localparam int unsigned HI = LO + SEG;
    localparam int unsigned UW = WIDTH - HI;

    // a_up/b_up hold the operand bits from LO upward; the skew register keeps only
    // the bits still ahead, so nothing already consumed is carried forward.
    logic [WIDTH-LO-1:0] a_up, b_up;
    logic                ci, co, v_in;
    logic [SEG-1:0]      s_seg;
    logic [HI-1:0]       s_next;
    logic                v_q, c_q;
    logic [HI-1:0]       s_q;
`ifdef PIPE_ADD_SAT_EN
    logic                sat_in;
`endif

    if (k == 0) begin : g_in
      assign a_up   = bus.a;
      assign b_up   = bus.b;
      assign ci     = bus.cin;
      assign v_in   = bus.in_valid;
      assign s_next = s_seg;
`ifdef PIPE_ADD_SAT_EN
      assign sat_in = bus.sat;
`endif
    end else begin : g_in
      assign a_up   = g_stage[k-1].g_skew.a_q;
      assign b_up   = g_stage[k-1].g_skew.b_q;
      assign ci     = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].v_q;
      assign s_next = {s_seg, g_stage[k-1].s_q};
`ifdef PIPE_ADD_SAT_EN
      assign sat_in = g_stage[k-1].g_skew.sat_q;
`endif
    end

    pipe_add_seg #(.SEG(SEG)) u_seg (
      .a  (a_up[SEG-1:0]),
      .b  (b_up[SEG-1:0]),
      .ci (ci),
      .s  (s_seg),
      .co (co)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= co;
`ifdef PIPE_ADD_SAT_EN
        s_q <= (k == STAGES - 1 && sat_in && co) ? '1 : s_next;
`else
        s_q <= s_next;
`endif
      end
    end

    if (UW > 0) begin : g_skew
      logic [UW-1:0] a_q, b_q;
`ifdef PIPE_ADD_SAT_EN
      logic          sat_q;
`endif
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
`ifdef PIPE_ADD_SAT_EN
          sat_q <= 1'b0;
`endif
        end else if (advance) begin
          a_q <= a_up[WIDTH-LO-1:SEG];
          b_q <= b_up[WIDTH-LO-1:SEG];
`ifdef PIPE_ADD_SAT_EN
          sat_q <= sat_in;
`endif
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.sum       = g_stage[STAGES-1].s_q;
  assign bus.cout      = g_stage[STAGES-1].c_q;

endmodule
